// File: rtl/chip8_pkg.sv
// chip8_pkg: shared init-sequencer state type and CHIP-8 memory map constants
package chip8_pkg;
  typedef enum logic [1:0] {CLEAR, FONT, ROM, DONE} init_state_e;
  localparam int FONT_ROWS = 5;
  localparam int FONT_BYTES = 16 * FONT_ROWS;
  localparam int DEF_MEM_DEPTH = 4096;
  localparam int DEF_ADDR_W = 12;
  localparam int DEF_FONT_BASE = 0;
  localparam int DEF_ROM_BASE = 'h200;
  localparam int DEF_ROM_MAX_BYTES = 3584;
endpackage

// File: rtl/chip8_font_rom.sv
// chip8_font_rom: combinational hex fontset lookup, digits 0..F with five rows each
module chip8_font_rom
  import chip8_pkg::*;
(
  input  logic [6:0] idx,
  output logic [7:0] data
);
  localparam logic [7:0] FONT_TBL [FONT_BYTES] = '{
    8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,
    8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
    8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,
    8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
    8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,
    8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,
    8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,
    8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,
    8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,
    8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
  };
  assign data = (idx < 7'(FONT_BYTES)) ? FONT_TBL[idx] : 8'h00;
endmodule

// File: rtl/chip8_mem_init.sv
// chip8_mem_init: writes fontset then streamed program image into CHIP-8 memory; CHIP8_MEM_CLEAR_EN adds a leading zero-fill pass
module chip8_mem_init
  import chip8_pkg::*;
#(
  parameter int MEM_DEPTH = DEF_MEM_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int FONT_BASE = DEF_FONT_BASE,
  parameter int ROM_BASE = DEF_ROM_BASE,
  parameter int ROM_MAX_BYTES = DEF_ROM_MAX_BYTES
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start_in,
  input  logic              rom_valid_in,
  input  logic [7:0]        rom_data_in,
  input  logic              rom_last_in,
  output logic              rom_ready_out,
  output logic              mem_we_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic [7:0]        mem_wdata_out,
  output logic              busy_out,
  output logic              done_out,
  output logic [ADDR_W:0]   rom_len_out,
  output logic              overflow_out
);
`ifdef CHIP8_MEM_CLEAR_EN
  localparam init_state_e FIRST = CLEAR;
`else
  localparam init_state_e FIRST = FONT;
`endif
  if (MEM_DEPTH > 2**ADDR_W || ADDR_W < 7 || ROM_MAX_BYTES < 1 ||
      ROM_BASE + ROM_MAX_BYTES > MEM_DEPTH || FONT_BASE + FONT_BYTES > MEM_DEPTH) begin : g_bad_params
    $error("chip8_mem_init: inconsistent memory map parameters");
  end
  init_state_e state;
  logic [ADDR_W-1:0] idx;
  logic [7:0] font_byte;
  logic xfer, at_cap;
  chip8_font_rom u_font (
    .idx  (idx[6:0]),
    .data (font_byte)
  );
  assign rom_ready_out = (state == ROM) && (rom_len_out < (ADDR_W+1)'(ROM_MAX_BYTES));
  assign xfer = rom_valid_in && rom_ready_out;
  assign at_cap = rom_len_out == (ADDR_W+1)'(ROM_MAX_BYTES - 1);
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= FIRST;
      idx <= '0;
      rom_len_out <= '0;
      overflow_out <= 1'b0;
      mem_we_out <= 1'b0;
      mem_addr_out <= '0;
      mem_wdata_out <= '0;
      busy_out <= 1'b0;
      done_out <= 1'b0;
    end else begin
      mem_we_out <= 1'b0;
      busy_out <= 1'b1;
      done_out <= 1'b0;
      case (state)
        CLEAR: begin
          mem_we_out <= 1'b1;
          mem_addr_out <= idx;
          mem_wdata_out <= 8'h00;
          idx <= (idx == ADDR_W'(MEM_DEPTH - 1)) ? '0 : idx + 1'b1;
          if (idx == ADDR_W'(MEM_DEPTH - 1)) state <= FONT;
        end
        FONT: begin
          mem_we_out <= 1'b1;
          mem_addr_out <= ADDR_W'(FONT_BASE) + idx;
          mem_wdata_out <= font_byte;
          idx <= idx + 1'b1;
          if (idx == ADDR_W'(FONT_BYTES - 1)) state <= ROM;
        end
        ROM: if (xfer) begin
          mem_we_out <= 1'b1;
          mem_addr_out <= ADDR_W'(ROM_BASE) + rom_len_out[ADDR_W-1:0];
          mem_wdata_out <= rom_data_in;
          rom_len_out <= rom_len_out + 1'b1;
          // hitting the cap without a last marker means the image was truncated
          if (rom_last_in || at_cap) begin
            state <= DONE;
            overflow_out <= !rom_last_in;
          end
        end
        DONE: if (start_in) begin
          state <= FIRST;
          idx <= '0;
          rom_len_out <= '0;
          overflow_out <= 1'b0;
        end else begin
          busy_out <= 1'b0;
          done_out <= 1'b1;
        end
        default: state <= FIRST;
      endcase
    end
  end
endmodule
